// File: rtl/vram_scheduler.sv
// vram_scheduler: divides each 8-slot character cell of the shared VRAM/main RAM
// between video fetch, the Z80 and an optional loader/DMA requester.
// Define VRAM_SCHED_DMA_EN to enable the DMA port and its starvation override;
// without it the DMA outputs read as zero and only CPU accesses are granted.
module vram_scheduler #(
    parameter int unsigned CPU_SLOT   = 5,
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_6mn,
    input  logic [2:0]  slot,
    input  logic        narrow,
    input  logic        vid_busy,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    output logic        cpu_wait,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [18:0] dma_addr,
    input  logic [7:0]  dma_din,
    output logic [7:0]  dma_dout,
    output logic        dma_ack,
    output logic [18:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        mem_rd,
    input  logic [7:0]  mem_dout
);

    localparam logic [2:0] CPU_SLOT_L = 3'(CPU_SLOT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT1, DONE} state_t;

    state_t state;
    logic   owner;      // 0 = CPU, 1 = DMA
    logic   is_write;
    logic   slot_cpu;   // current slot may be used by the CPU
    logic   take;       // a grant decision happens this edge
    logic   override;   // DMA outranks the CPU in this slot
    logic   cpu_first;
    logic   cpu_win;

    assign slot_cpu  = (slot == CPU_SLOT_L) || (!narrow && (slot[1:0] == CPU_SLOT_L[1:0]));
    assign take      = ce_6mn && (state == IDLE);
    assign cpu_first = cpu_req && slot_cpu && !override;
    assign cpu_win   = take && cpu_first;
    assign cpu_wait  = cpu_req & ~cpu_ack;

`ifdef VRAM_SCHED_DMA_EN
    localparam logic [3:0] STARVE_MAX_L = 4'(STARVE_MAX);

    logic [3:0] starve;
    logic       dma_cand;   // DMA could use this slot if it wins arbitration
    logic       dma_win;

    assign dma_cand = dma_req && (slot_cpu || !vid_busy);
    assign override = dma_req && slot_cpu && (starve == STARVE_MAX_L);
    assign dma_win  = take && dma_cand && !cpu_first;

    // Starvation counter: counts DMA-capable slots that DMA did not get,
    // including slot strobes that arrive while an access is still in flight
    always_ff @(posedge clk_sys) begin
        if (reset || !dma_req) begin
            starve <= '0;
        end else if (ce_6mn) begin
            if (dma_win) begin
                starve <= '0;
            end else if (dma_cand && (starve != STARVE_MAX_L)) begin
                starve <= starve + 4'd1;
            end
        end
    end
`else
    logic unused_dma;

    assign override   = 1'b0;
    assign unused_dma = ^{dma_req, dma_we, dma_addr, dma_din, vid_busy};
    assign dma_ack    = 1'b0;
    assign dma_dout   = '0;
`endif

    // Access sequencer: grant in IDLE on ce_6mn, then ISSUE/WAIT1/DONE with registered strobes
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            is_write <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_we   <= 1'b0;
            mem_rd   <= 1'b0;
            cpu_ack  <= 1'b0;
            cpu_dout <= '0;
`ifdef VRAM_SCHED_DMA_EN
            dma_ack  <= 1'b0;
            dma_dout <= '0;
`endif
        end else begin
            mem_we  <= 1'b0;
            mem_rd  <= 1'b0;
            cpu_ack <= 1'b0;
`ifdef VRAM_SCHED_DMA_EN
            dma_ack <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cpu_win) begin
                        state    <= ISSUE;
                        owner    <= 1'b0;
                        is_write <= cpu_we;
                        mem_addr <= cpu_addr;
                        mem_din  <= cpu_din;
                        mem_we   <= cpu_we;
                        mem_rd   <= !cpu_we;
                    end
`ifdef VRAM_SCHED_DMA_EN
                    else if (dma_win) begin
                        state    <= ISSUE;
                        owner    <= 1'b1;
                        is_write <= dma_we;
                        mem_addr <= dma_addr;
                        mem_din  <= dma_din;
                        mem_we   <= dma_we;
                        mem_rd   <= !dma_we;
                    end
`endif
                end
                ISSUE: state <= WAIT1;
                WAIT1: state <= DONE;
                // Read data is valid two edges after the strobe; the ack and
                // capture are registered on leaving DONE, 3 clk after the grant
                DONE: begin
                    state <= IDLE;
                    if (!owner) begin
                        cpu_ack <= 1'b1;
                        if (!is_write) cpu_dout <= mem_dout;
                    end
`ifdef VRAM_SCHED_DMA_EN
                    else begin
                        dma_ack <= 1'b1;
                        if (!is_write) dma_dout <= mem_dout;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
